dl11_multi: RTL
===============

Name: dl11_multi

Overview:
- Multi-channel DL11-compatible serial line unit; successor to the single-line console UART.
- Presents NCHAN independent DL11 register blocks (RCSR/RBUF/XCSR/XBUF) to the CPU bus.
- Presents a 32-bit host port used by the host-side software to drain TX and inject RX bytes.
- Adds over the single-line unit: parametrised FIFO depth and channel count, interrupt enables with per-channel IRQ outputs, RX overrun detection, host fill counts, and FIFO flush. FIFOs are internal ring buffers.

Parameters:
- NCHAN, 4, number of serial lines (1..16).
- CHB, 2, channel-select bits (CHB = max(1, clog2(NCHAN))).
- DEPTH, 16, per-direction FIFO depth in bytes (power of two, 2..128).

Ports:
- clk  in  1  clock.
- busrst  in  1  reset, synchronous, active-high.
- uartreq  in  1  bus access strobe, one transaction per cycle high.
- uartaddr  in  CHB+3  [CHB+2:3]=channel, [2:1]=register, [0]=byte address (ignored).
- uartwr  in  1  1=write.
- uartwdata  in  16  bus write data.
- uartack  out  1  bus acknowledge.
- uartrdata  out  16  bus read data.
- uarthostreq  in  1  host access strobe.
- uarthostaddr  in  CHB+2  [CHB+1:2]=channel, [1:0]=register.
- uarthostwr  in  1  1=write.
- uarthostwdata  in  32  host write data.
- uarthostack  out  1  host acknowledge.
- uarthostrdata  out  32  host read data.
- rxirq  out  NCHAN  per-channel receive interrupt request (level).
- txirq  out  NCHAN  per-channel transmit interrupt request (level).

Behaviour:
- Reset: all FIFOs empty, IE bits 0, overrun flags 0, uartack=0, uarthostack=0, uartrdata=0, uarthostrdata=0, rxirq=0, txirq=0. Reset mid-transaction drops the transaction; no ack is issued.
- Ack latency: ack pulses exactly one cycle after each cycle of req; rdata is valid in the ack cycle.
- Read data: returns 0 for unused bits and for unmapped reads. Channel >= NCHAN: acked, reads 0, writes ignored.
- Bus registers (reg = addr[2:1]):
  - 0 RCSR: read {8'd0, DONE, IE, 6'd0}, DONE = RX FIFO non-empty. Write sets RX IE = wdata[6].
  - 1 RBUF: read {OVR, OVR, 6'd0, head byte}; pops RX if non-empty, clears OVR. When RX is empty the read returns byte 0 with no pop. Writes are ignored.
  - 2 XCSR: read {8'd0, READY, IE, 6'd0}, READY = TX FIFO not full. Write sets TX IE = wdata[6].
  - 3 XBUF: write pushes wdata[7:0] to TX if not full; if TX is full the byte is silently dropped. Reads return 0.
- Host registers:
  - 0 read: {!txempty, 23'd0, TX head}; pops TX if non-empty.
  - 0 write: pushes wdata[7:0] to RX if not full; otherwise the byte is dropped and the channel OVR flag is set (sticky).
  - 1 read: {!rxfull, 7'd0, rxcount[7:0], 8'd0, txcount[7:0]}.
  - 1 write: wdata[0]=1 flushes TX, wdata[1]=1 flushes RX and clears OVR.
  - 2, 3: read 0; writes ignored.
- FIFO rules:
  - Full/empty are evaluated on state at the start of the cycle; there is no bypass.
  - Push and pop in the same cycle are both honoured when individually legal: count unchanged, pointers advance. The full case pops only; the empty case pushes only.
  - Flush in the same cycle as a push or pop: flush wins, FIFO empty afterwards.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits; count == DEPTH means full.
  - Flags and counts update the cycle after the push/pop.
  - Bus and host may access the same channel in the same cycle.
- Interrupts: rxirq[i] = RX IE & DONE; txirq[i] = TX IE & READY. Both are registered and change one cycle after the underlying state.

Test Plan:
- Reset, then bus read RCSR/XCSR ch0 -> 0x0000 / 0x0080; host read reg1 ch0 -> 0x80000000; irqs 0.
- Bus write XBUF ch2 0x41,0x42; host read reg0 ch2 x3 -> 0x80000041, 0x80000042, 0x00000000 (pops only twice).
- Host write 17 bytes 0x00..0x10 to ch1 RX (DEPTH=16) -> reg1 rxcount=16, !rxfull=0. First RBUF read -> 0xC000, next -> 0x0001; OVR then clear.
- Bus write RCSR ch3 0x0040, host push 0x55 -> rxirq[3]=1 two cycles after push. RBUF read 0x0055 -> rxirq[3]=0.
- Same cycle: host push RX ch0 and bus RBUF read on a 1-entry RX -> old head returned, new byte remains, rxcount=1.
- Fill TX ch0 to 16, host write reg1 0x1 same cycle as XBUF write -> txcount=0, XCSR=0x0080.

Source files
------------

// File: rtl/dl11_multi_if.sv
// Bus-side and host-side access channels of the multi-line DL11 unit.
// The CPU bus and the host port each carry one request per cycle; ack follows one cycle later.
interface dl11_multi_if #(
  parameter int CHB = 2
);
  logic            uartreq;
  logic [CHB+2:0]  uartaddr;
  logic            uartwr;
  logic [15:0]     uartwdata;
  logic            uartack;
  logic [15:0]     uartrdata;

  logic            uarthostreq;
  logic [CHB+1:0]  uarthostaddr;
  logic            uarthostwr;
  logic [31:0]     uarthostwdata;
  logic            uarthostack;
  logic [31:0]     uarthostrdata;

  modport master (
    output uartreq, uartaddr, uartwr, uartwdata,
    input  uartack, uartrdata,
    output uarthostreq, uarthostaddr, uarthostwr, uarthostwdata,
    input  uarthostack, uarthostrdata
  );

  modport slave (
    input  uartreq, uartaddr, uartwr, uartwdata,
    output uartack, uartrdata,
    input  uarthostreq, uarthostaddr, uarthostwr, uarthostwdata,
    output uarthostack, uarthostrdata
  );
endinterface

// File: rtl/dl11_multi.sv
// Multi-channel DL11-compatible serial line unit: per-channel RCSR/RBUF/XCSR/XBUF on the
// CPU bus, a 32-bit host port draining TX and injecting RX, and per-channel level IRQs.
module dl11_multi #(
  parameter int NCHAN = 4,
  parameter int CHB   = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             busrst,
  dl11_multi_if.slave      bus,
  output logic [NCHAN-1:0] rxirq,
  output logic [NCHAN-1:0] txirq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CHB:0]  NCHAN_W = (CHB+1)'(NCHAN);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    BREG_RCSR = 2'd0,
    BREG_RBUF = 2'd1,
    BREG_XCSR = 2'd2,
    BREG_XBUF = 2'd3
  } breg_e;

  typedef enum logic [1:0] {
    HREG_DATA = 2'd0,
    HREG_STAT = 2'd1,
    HREG_RSV2 = 2'd2,
    HREG_RSV3 = 2'd3
  } hreg_e;

  typedef struct packed {
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
  } fifo_t;

  // Ring-buffer occupancy update; flush overrides any concurrent push or pop.
  function automatic fifo_t fifo_next(input fifo_t f, input logic push, input logic pop,
                                      input logic flush);
    fifo_t n;
    n = f;
    if (flush) begin
      n = '0;
    end else begin
      if (push) n.wp = f.wp + 1'b1;
      if (pop)  n.rp = f.rp + 1'b1;
      if (push && !pop)      n.cnt = f.cnt + 1'b1;
      else if (pop && !push) n.cnt = f.cnt - 1'b1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- state
  fifo_t            rx_q [NCHAN];
  fifo_t            rx_d [NCHAN];
  fifo_t            tx_q [NCHAN];
  fifo_t            tx_d [NCHAN];
  logic [7:0]       rx_mem_q [NCHAN][DEPTH];
  logic [7:0]       tx_mem_q [NCHAN][DEPTH];

  logic [NCHAN-1:0] rx_ie_q, rx_ie_d;
  logic [NCHAN-1:0] tx_ie_q, tx_ie_d;
  logic [NCHAN-1:0] ovr_q,   ovr_d;
  logic [NCHAN-1:0] rxirq_q, rxirq_d;
  logic [NCHAN-1:0] txirq_q, txirq_d;

  logic             b_ack_q, b_ack_d;
  logic [15:0]      b_rdata_q, b_rdata_d;
  logic             h_ack_q, h_ack_d;
  logic [31:0]      h_rdata_q, h_rdata_d;

  // ---------------------------------------------------------------- decode
  logic [CHB-1:0]   b_ch, h_ch;
  breg_e            b_reg;
  hreg_e            h_reg;
  logic             b_ok, h_ok;
  logic             b_rd, b_wr, h_rd, h_wr;
  logic [NCHAN-1:0] b_sel, h_sel;

  assign b_ch  = bus.uartaddr[CHB+2:3];
  assign b_reg = breg_e'(bus.uartaddr[2:1]);
  assign h_ch  = bus.uarthostaddr[CHB+1:2];
  assign h_reg = hreg_e'(bus.uarthostaddr[1:0]);

  // Out-of-range channels are still acked but never touch any channel state.
  assign b_ok = ({1'b0, b_ch} < NCHAN_W);
  assign h_ok = ({1'b0, h_ch} < NCHAN_W);

  assign b_rd = bus.uartreq     & ~bus.uartwr     & b_ok;
  assign b_wr = bus.uartreq     &  bus.uartwr     & b_ok;
  assign h_rd = bus.uarthostreq & ~bus.uarthostwr & h_ok;
  assign h_wr = bus.uarthostreq &  bus.uarthostwr & h_ok;

  logic unused_bits;
  assign unused_bits = ^{bus.uartaddr[0], bus.uartwdata[15:8], bus.uarthostwdata[31:8]};

  // ---------------------------------------------------------------- flags
  logic [NCHAN-1:0] rx_empty, rx_full, tx_empty, tx_full;

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    rx_empty = '0;
    rx_full  = '0;
    tx_empty = '0;
    tx_full  = '0;
    b_sel    = '0;
    h_sel    = '0;
    for (int i = 0; i < NCHAN; i++) begin
      rx_empty[i] = (rx_q[i].cnt == '0);
      rx_full[i]  = (rx_q[i].cnt == FULL_CNT);
      tx_empty[i] = (tx_q[i].cnt == '0);
      tx_full[i]  = (tx_q[i].cnt == FULL_CNT);
      b_sel[i]    = b_ok && (b_ch == CHB'(i));
      h_sel[i]    = h_ok && (h_ch == CHB'(i));
    end
  end

  // ---------------------------------------------------------------- FIFO events
  logic [NCHAN-1:0] rx_push, rx_pop, rx_flush;
  logic [NCHAN-1:0] tx_push, tx_pop, tx_flush;
  logic [NCHAN-1:0] rbuf_rd, ovr_set;

  always_comb begin
    rx_push  = '0;
    rx_pop   = '0;
    rx_flush = '0;
    tx_push  = '0;
    tx_pop   = '0;
    tx_flush = '0;
    rbuf_rd  = '0;
    ovr_set  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      rbuf_rd[i]  = b_rd && b_sel[i] && (b_reg == BREG_RBUF);
      rx_pop[i]   = rbuf_rd[i] && !rx_empty[i];
      tx_push[i]  = b_wr && b_sel[i] && (b_reg == BREG_XBUF) && !tx_full[i];
      rx_push[i]  = h_wr && h_sel[i] && (h_reg == HREG_DATA) && !rx_full[i];
      ovr_set[i]  = h_wr && h_sel[i] && (h_reg == HREG_DATA) &&  rx_full[i];
      tx_pop[i]   = h_rd && h_sel[i] && (h_reg == HREG_DATA) && !tx_empty[i];
      tx_flush[i] = h_wr && h_sel[i] && (h_reg == HREG_STAT) && bus.uarthostwdata[0];
      rx_flush[i] = h_wr && h_sel[i] && (h_reg == HREG_STAT) && bus.uarthostwdata[1];
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    ovr_d   = ovr_q;
    rxirq_d = '0;
    txirq_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      rx_d[i] = fifo_next(rx_q[i], rx_push[i], rx_pop[i], rx_flush[i]);
      tx_d[i] = fifo_next(tx_q[i], tx_push[i], tx_pop[i], tx_flush[i]);
      if (b_wr && b_sel[i] && (b_reg == BREG_RCSR)) rx_ie_d[i] = bus.uartwdata[6];
      if (b_wr && b_sel[i] && (b_reg == BREG_XCSR)) tx_ie_d[i] = bus.uartwdata[6];
      // A fresh overrun outranks the clear from a concurrent RBUF read.
      if (rbuf_rd[i] || rx_flush[i]) ovr_d[i] = 1'b0;
      if (ovr_set[i])                ovr_d[i] = 1'b1;
      rxirq_d[i] = rx_ie_q[i] & ~rx_empty[i];
      txirq_d[i] = tx_ie_q[i] & ~tx_full[i];
    end
  end

  // ---------------------------------------------------------------- read muxes
  always_comb begin
    b_ack_d   = bus.uartreq;
    b_rdata_d = '0;
    if (b_rd) begin
      unique case (b_reg)
        BREG_RCSR: b_rdata_d = {8'd0, ~rx_empty[b_ch], rx_ie_q[b_ch], 6'd0};
        BREG_RBUF: b_rdata_d = {ovr_q[b_ch], ovr_q[b_ch], 6'd0,
                                rx_empty[b_ch] ? 8'd0 : rx_mem_q[b_ch][rx_q[b_ch].rp]};
        BREG_XCSR: b_rdata_d = {8'd0, ~tx_full[b_ch], tx_ie_q[b_ch], 6'd0};
        BREG_XBUF: b_rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    h_ack_d   = bus.uarthostreq;
    h_rdata_d = '0;
    if (h_rd) begin
      unique case (h_reg)
        HREG_DATA: h_rdata_d = {~tx_empty[h_ch], 23'd0,
                                tx_empty[h_ch] ? 8'd0 : tx_mem_q[h_ch][tx_q[h_ch].rp]};
        HREG_STAT: h_rdata_d = {~rx_full[h_ch], 7'd0, 8'(rx_q[h_ch].cnt),
                                8'd0, 8'(tx_q[h_ch].cnt)};
        HREG_RSV2, HREG_RSV3: h_rdata_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (busrst) begin
      b_ack_q   <= 1'b0;
      b_rdata_q <= '0;
      h_ack_q   <= 1'b0;
      h_rdata_q <= '0;
      rx_ie_q   <= '0;
      tx_ie_q   <= '0;
      ovr_q     <= '0;
      rxirq_q   <= '0;
      txirq_q   <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        rx_q[i] <= '0;
        tx_q[i] <= '0;
      end
    end else begin
      b_ack_q   <= b_ack_d;
      b_rdata_q <= b_rdata_d;
      h_ack_q   <= h_ack_d;
      h_rdata_q <= h_rdata_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
      ovr_q     <= ovr_d;
      rxirq_q   <= rxirq_d;
      txirq_q   <= txirq_d;
      for (int i = 0; i < NCHAN; i++) begin
        rx_q[i] <= rx_d[i];
        tx_q[i] <= tx_d[i];
      end
    end
  end

  // NOTE: byte storage is left unreset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (rx_push[i]) rx_mem_q[i][rx_q[i].wp] <= bus.uarthostwdata[7:0];
      if (tx_push[i]) tx_mem_q[i][tx_q[i].wp] <= bus.uartwdata[7:0];
    end
  end

  assign bus.uartack       = b_ack_q;
  assign bus.uartrdata     = b_rdata_q;
  assign bus.uarthostack   = h_ack_q;
  assign bus.uarthostrdata = h_rdata_q;
  assign rxirq             = rxirq_q;
  assign txirq             = txirq_q;

endmodule
